// File: rtl/lcg_stim_gen.sv
// Hardware twin of the harness's 32-bit LCG stimulus source: fills IN_W-bit
// vectors 32 bits per cycle and offers each one over a valid/ready handshake.
module lcg_stim_gen #(
  parameter int          IN_W  = 139,
  parameter logic [31:0] LCG_A = 32'h41C64E6D,
  parameter logic [31:0] LCG_C = 32'h3039
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     seed,
  input  logic [31:0]     num_vectors,
  output logic            vec_valid,
  input  logic            vec_ready,
  output logic [IN_W-1:0] vec_data,
  output logic [31:0]     vec_count,
  output logic            busy,
  output logic            done
);

  localparam int NCHUNK = (IN_W + 31) / 32;
  localparam int LAST_W = IN_W - 32 * (NCHUNK - 1);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_HOLD, S_DONE} state_t;

  state_t            state_reg;
  logic [31:0]       rng_reg;
  logic [31:0]       rng_next;
  logic [31:0]       num_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [IN_W-1:0]   vec_data_reg;
  logic [IN_W-1:0]   vec_data_next;
  logic [31:0]       vec_count_reg;
  logic              vec_valid_reg;
  logic              busy_reg;
  logic              done_reg;

  assign rng_next = rng_reg * LCG_A + LCG_C;

  // Each chunk is overwritten in place only on its own GEN cycle; the last
  // chunk keeps just the low LAST_W bits of the LCG state.
  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      localparam int LO = 32 * gi;
      localparam int W  = (gi == NCHUNK - 1) ? LAST_W : 32;
      assign vec_data_next[LO +: W] =
        (state_reg == S_GEN && idx_reg == IDX_W'(gi)) ? rng_next[W-1:0]
                                                      : vec_data_reg[LO +: W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      rng_reg       <= '0;
      num_reg       <= '0;
      idx_reg       <= '0;
      vec_data_reg  <= '0;
      vec_count_reg <= '0;
      vec_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            rng_reg       <= seed;
            num_reg       <= num_vectors;
            idx_reg       <= '0;
            vec_data_reg  <= '0;
            vec_count_reg <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= (num_vectors == 32'd0) ? S_DONE : S_GEN;
          end
        end
        S_GEN: begin
          rng_reg      <= rng_next;
          vec_data_reg <= vec_data_next;
          if (idx_reg == LAST_IDX) begin
            idx_reg       <= '0;
            vec_valid_reg <= 1'b1;
            state_reg     <= S_HOLD;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_HOLD: begin
          if (vec_ready) begin
            vec_valid_reg <= 1'b0;
            vec_count_reg <= vec_count_reg + 32'd1;
            state_reg     <= (vec_count_reg + 32'd1 == num_reg) ? S_DONE : S_GEN;
          end
        end
        S_DONE: begin
          // done is seen in the first IDLE cycle, after busy has dropped
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign vec_valid = vec_valid_reg;
  assign vec_data  = vec_data_reg;
  assign vec_count = vec_count_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: doc/lcg_stim_gen.md
# lcg_stim_gen

Synthesizable stimulus source that sits directly upstream of the DUT `in_flat` input in the fuzzing harness. It reproduces the harness's 32-bit linear congruential generator in hardware and emits a sequence of `IN_W`-bit vectors over a valid/ready handshake. Each vector is filled 32 bits at a time, so the hardware-driven stimulus stream is bit-identical to the software-driven one for the same seed.

## Interface
- `IN_W`, default 139: vector width in bits, ≥1. `NCHUNK` = ceil(`IN_W`/32), derived (5 at default).
- `LCG_A`, default 32'h41C64E6D: LCG multiplier.
- `LCG_C`, default 32'h3039: LCG increment.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  begin a run; sampled in IDLE only.
- `seed`  in  32  initial LCG state; sampled with `start`.
- `num_vectors`  in  32  vectors to emit per run; sampled with `start`.
- `vec_valid`  out  1  `vec_data` holds a complete vector.
- `vec_ready`  in  1  consumer accepts the vector.
- `vec_data`  out  `IN_W`  current vector.
- `vec_count`  out  32  vectors accepted so far in this run.
- `busy`  out  1  high in GEN, HOLD or DONE.
- `done`  out  1  one-cycle pulse at end of run.

## Operation
- LCG step: `rng <= rng*LCG_A + LCG_C`, truncated mod 2^32. All arithmetic is unsigned 32-bit.
- Chunk k (0..`NCHUNK`-1) receives the state after the (k+1)-th step of that vector.
  - Chunk k maps to `vec_data[32k+31:32k]`.
  - The last chunk takes only the low (`IN_W`-32(`NCHUNK`-1)) bits of the state.
- The LCG state carries across vectors; there is no reseed between vectors.
- FSM states: IDLE, GEN, HOLD, DONE.
  - **IDLE.** When `start`=1, latch `seed` into `rng` and latch `num_vectors`, and clear `vec_count`, `vec_data` and the chunk index. If `num_vectors`=0, go to DONE; otherwise go to GEN.
  - **GEN.** Perform one LCG step per cycle and write the next state into chunk[idx]. After chunk `NCHUNK`-1 is written, go to HOLD.
  - **HOLD.** `vec_valid`=1 and `vec_data` is stable. On `vec_valid && vec_ready`, increment `vec_count`. If the new count equals the latched `num_vectors`, go to DONE; otherwise go to GEN with idx=0.
  - **DONE.** `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored. `seed` and `num_vectors` changes after capture have no effect.
- `vec_data` is not cleared between vectors; chunks are overwritten in place. The consumer must only sample it while `vec_valid`=1.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state=IDLE, `rng`=0, idx=0.
  - `vec_data`=0, `vec_count`=0.
  - `vec_valid`=0, `busy`=0, `done`=0.
- All outputs are registered.
- If `start` is sampled at edge T, chunks are written at edges T+1..T+`NCHUNK` and `vec_valid` rises after edge T+`NCHUNK`.
- Handshake accepted at edge H: `vec_valid` falls after H. The next `vec_valid` rises after H+`NCHUNK`.
  - Sustained throughput is 1 vector per `NCHUNK`+1 cycles, with `vec_ready` tied high.
- `vec_ready` is ignored outside HOLD. `vec_valid` never drops without a handshake, except on reset.
- `num_vectors`=0: `busy` is high for 1 cycle and `done` pulses the following cycle. No `vec_valid` is produced.
- `num_vectors`=2^32-1: the count saturates nowhere. The run ends when `vec_count` equals the latched value.
- Reset mid-run: the run is abandoned with no `done` pulse. A new `start` must be issued.
- `start` in the same cycle that DONE returns to IDLE is not accepted. It is accepted from the next IDLE cycle on.

## Test plan
- Seed 0, `IN_W`=139, `num_vectors`=1, `vec_ready`=1:
  - first `vec_data[31:0]`=32'h00003039 and `[63:32]`=32'hD3DC167E;
  - `vec_valid` is high after 5 cycles;
  - `done` pulses 2 cycles after the handshake, and `vec_count`=1.
- Seed 2169654598, `num_vectors`=200, `vec_ready` tied high: 200 vectors match a software LCG model chunk by chunk. `[138:128]` equals the low 11 bits of step 5. One vector every 6 cycles.
- Backpressure: hold `vec_ready`=0 for 10 cycles in HOLD. `vec_valid` stays high and `vec_data` is unchanged. No extra LCG steps occur; the next vector continues the sequence.
- `num_vectors`=0 with `start`: `vec_valid` never rises, `done`=1 exactly once, `vec_count`=0.
- `start` pulsed during GEN with a different seed: ignored, and the sequence continues from the original seed.
- `rst_n` dropped in HOLD after 3 vectors: all outputs are 0 immediately. A fresh `start` with the same seed reproduces the original first vector.
